timer_preload_sequencer: RTL and testbench

Bus-master sequencer that gives the advanced timer glitch-free, update-synchronous compare-value reloads. Software deposits new compare values into per-channel shadow registers at any time; on the next timer update event the block walks the pending channels and writes each shadow value into that channel's TCCR register over the peripheral bus. It sits between the CPU-side register file and the timer's `bus_protocol_if` peripheral port, alongside or muxed with the CPU path.

---
 rtl/timer_seq_pkg.sv | 33 +++
 rtl/timer_seq_prio_enc.sv | 26 ++
 rtl/timer_preload_sequencer.sv | 158 +++++++++++++++
 tb/tb_timer_preload_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_seq_pkg.sv
// Shared types, register map and helpers for the timer preload sequencer.
// Optional TARR preload is enabled by defining TIMER_SEQ_ARR_EN.
package timer_seq_pkg;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t SEQ_IDLE  = 2'd0;
    localparam seq_state_t SEQ_WRITE = 2'd1;
    localparam seq_state_t SEQ_DONE  = 2'd2;

    // Word indices of the timer's fixed registers relative to TCNT.
    localparam int unsigned REG_TCNT = 0;
    localparam int unsigned REG_TCR  = 1;
    localparam int unsigned REG_TPSC = 2;
    localparam int unsigned REG_TARR = 3;

    // TCCR registers follow the fixed block and a CHANNELS-deep capture block.
    function automatic int unsigned tccr_index(input int unsigned c, input int unsigned channels);
        return REG_TARR + 1 + channels + c;
    endfunction

    function automatic logic [3:0] strobe_for_width(input int unsigned bits);
        logic [3:0]  s;
        int unsigned nbytes;
        nbytes = (bits + 7) / 8;
        s = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i < nbytes) s[i] = 1'b1;
        end
        return s;
    endfunction

endpackage

// File: rtl/timer_seq_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
// Used by timer_preload_sequencer (TIMER_SEQ_ARR_EN has no effect here).
module timer_seq_prio_enc
    import timer_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        // Scan downward so the lowest set bit is the last assignment.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_preload_sequencer.sv
// Bus-master that replays shadowed compare values into the timer's TCCRs on an update event.
// Define TIMER_SEQ_ARR_EN to add a TARR shadow (index CHANNELS) that is written first.
module timer_preload_sequencer
    import timer_seq_pkg::*;
#(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned BITS_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            shadow_we,
    input  logic [$clog2(CHANNELS+1)-1:0]   shadow_sel,
    input  logic [BITS_WIDTH-1:0]           shadow_data,
    input  logic                            upd_evt,
    output logic [31:0]                     m_addr,
    output logic                            m_wen,
    output logic [31:0]                     m_wdata,
    output logic [3:0]                      m_strobe,
    input  logic                            m_request_stall,
    input  logic                            m_error,
    output logic [CHANNELS:0]               pending,
    output logic                            busy,
    output logic                            done,
    output logic                            overrun,
    output logic                            err_sticky
);

    localparam int unsigned SEL_W = $clog2(CHANNELS + 1);
    localparam int unsigned ENC_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned NIDX  = CHANNELS + 1;

    seq_state_t            state_q, state_d;
    logic [BITS_WIDTH-1:0] shadow_q [NIDX];
    logic [NIDX-1:0]       pending_q, pending_d;
    logic [NIDX-1:0]       active_q, active_d;
    logic [NIDX-1:0]       wr_oh, tgt_oh, pend_merged;
    logic                  busy_q, done_q, overrun_q, err_q;
    logic                  sel_ok, tarr_first, tgt_valid, accept;
    logic [SEL_W-1:0]      tgt;
    logic [ENC_W-1:0]      enc_idx;
    logic                  enc_valid;

    timer_seq_prio_enc #(
        .WIDTH (CHANNELS),
        .IDX_W (ENC_W)
    ) u_prio_enc (
        .req   (active_q[CHANNELS-1:0]),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    // Shadow write decode.
    always_comb begin
`ifdef TIMER_SEQ_ARR_EN
        sel_ok = (shadow_sel <= SEL_W'(CHANNELS));
`else
        sel_ok = (shadow_sel < SEL_W'(CHANNELS));
`endif
        wr_oh = '0;
        if (shadow_we && sel_ok) wr_oh[shadow_sel] = 1'b1;
    end

    // Target selection: TARR always beats the channels.
    always_comb begin
`ifdef TIMER_SEQ_ARR_EN
        tarr_first = active_q[CHANNELS];
`else
        tarr_first = 1'b0;
`endif
        tgt_valid = enc_valid | active_q[CHANNELS];
        tgt       = tarr_first ? SEL_W'(CHANNELS) : SEL_W'(enc_idx);
        tgt_oh    = '0;
        tgt_oh[tgt] = 1'b1;
    end

    // Bus outputs depend only on registered state, never on the stall input.
    always_comb begin
        m_wen    = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        m_strobe = '0;
        if (state_q == SEQ_WRITE && tgt_valid) begin
            m_wen    = 1'b1;
            m_wdata  = 32'(shadow_q[tgt]);
            m_strobe = strobe_for_width(BITS_WIDTH);
            if (tarr_first) begin
                m_addr = BASE_ADDR + 32'(4 * REG_TARR);
            end else begin
                m_addr = BASE_ADDR + 32'(4 * tccr_index(32'(tgt), CHANNELS));
            end
        end
    end

    assign accept = m_wen & ~m_request_stall;

    always_comb begin
        pend_merged = pending_q | wr_oh;
        pending_d   = pend_merged;
        active_d    = active_q;
        state_d     = state_q;
        case (state_q)
            SEQ_IDLE: begin
                // A same-cycle shadow write joins this snapshot.
                if (upd_evt && (|pend_merged)) begin
                    active_d  = pend_merged;
                    pending_d = '0;
                    state_d   = SEQ_WRITE;
                end
            end
            SEQ_WRITE: begin
                if (accept) begin
                    active_d = active_q & ~tgt_oh;
                    if (active_d == '0) state_d = SEQ_DONE;
                end
            end
            SEQ_DONE: state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SEQ_IDLE;
            pending_q <= '0;
            active_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            active_q  <= active_d;
            busy_q    <= (state_d != SEQ_IDLE);
            done_q    <= (state_d == SEQ_DONE);
            overrun_q <= upd_evt && (state_q != SEQ_IDLE);
            err_q     <= err_q | (accept & m_error);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NIDX; i++) begin
            if (rst) begin
                shadow_q[i] <= '0;
            end else if (wr_oh[i]) begin
                shadow_q[i] <= shadow_data;
            end
        end
    end

    assign pending    = pending_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overrun    = overrun_q;
    assign err_sticky = err_q;

endmodule

// File: tb/tb_timer_preload_sequencer.sv
// Directed self-checking bench for timer_preload_sequencer (8 channels, 16-bit registers).
// Covers the TARR path when built with TIMER_SEQ_ARR_EN.
module tb_timer_preload_sequencer;

    localparam int unsigned CH   = 8;
    localparam int unsigned BW   = 16;
    localparam logic [31:0] BASE = 32'h4000_1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          shadow_we;
    logic [3:0]    shadow_sel;
    logic [BW-1:0] shadow_data;
    logic          upd_evt;
    logic [31:0]   m_addr;
    logic          m_wen;
    logic [31:0]   m_wdata;
    logic [3:0]    m_strobe;
    logic          m_request_stall;
    logic          m_error;
    logic [CH:0]   pending;
    logic          busy;
    logic          done;
    logic          overrun;
    logic          err_sticky;

    int n_checks = 0;
    int n_errors = 0;

    timer_preload_sequencer #(
        .CHANNELS   (CH),
        .BITS_WIDTH (BW),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .shadow_we       (shadow_we),
        .shadow_sel      (shadow_sel),
        .shadow_data     (shadow_data),
        .upd_evt         (upd_evt),
        .m_addr          (m_addr),
        .m_wen           (m_wen),
        .m_wdata         (m_wdata),
        .m_strobe        (m_strobe),
        .m_request_stall (m_request_stall),
        .m_error         (m_error),
        .pending         (pending),
        .busy            (busy),
        .done            (done),
        .overrun         (overrun),
        .err_sticky      (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shadow_wr(input logic [3:0] sel, input logic [BW-1:0] data);
        shadow_we   = 1'b1;
        shadow_sel  = sel;
        shadow_data = data;
        tick();
        shadow_we   = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
        check_val({tag, "_wen"}, 32'(m_wen), 32'd1);
        check_val({tag, "_addr"}, m_addr, addr);
        check_val({tag, "_data"}, m_wdata, data);
    endtask

    initial begin
        rst = 1'b1; shadow_we = 1'b0; shadow_sel = '0; shadow_data = '0;
        upd_evt = 1'b0; m_request_stall = 1'b0; m_error = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_val("rst_wen", 32'(m_wen), 32'd0);
        check_val("rst_addr", m_addr, 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err_sticky), 32'd0);

        // Basic reload: ch2 then ch5, back-to-back.
        shadow_wr(4'd2, 16'h0100);
        shadow_wr(4'd5, 16'h0080);
        check_val("basic_pending", 32'(pending), 32'h024);
        upd_evt = 1'b1; tick(); upd_evt = 1'b0;
        check_write("basic_ch2", BASE + 32'h38, 32'h100);
        check_val("basic_strobe", 32'(m_strobe), 32'h3);
        check_val("basic_busy", 32'(busy), 32'd1);
        check_val("basic_pend0", 32'(pending), 32'd0);
        tick();
        check_write("basic_ch5", BASE + 32'h44, 32'h80);
        tick();
        check_val("basic_done", 32'(done), 32'd1);
        check_val("basic_done_wen", 32'(m_wen), 32'd0);
        check_val("basic_done_addr", m_addr, 32'd0);
        check_val("basic_done_busy", 32'(busy), 32'd1);
        tick();
        check_val("basic_done_pulse", 32'(done), 32'd0);
        check_val("basic_idle_busy", 32'(busy), 32'd0);

        // Three stall cycles on the first write.
        shadow_wr(4'd2, 16'h1234);
        shadow_wr(4'd5, 16'h0055);
        upd_evt = 1'b1; tick(); upd_evt = 1'b0;
        m_request_stall = 1'b1;
        check_write("stall_t1", BASE + 32'h38, 32'h1234);
        tick();
        check_write("stall_t2", BASE + 32'h38, 32'h1234);
        tick();
        check_write("stall_t3", BASE + 32'h38, 32'h1234);
        tick();
        m_request_stall = 1'b0;
        check_write("stall_t4", BASE + 32'h38, 32'h1234);
        tick();
        check_write("stall_t5", BASE + 32'h44, 32'h55);
        tick();
        check_val("stall_done", 32'(done), 32'd1);
        tick();

        // Event while busy, plus a rewrite of an already-written channel.
        shadow_wr(4'd0, 16'h0011);
        shadow_wr(4'd1, 16'h0022);
        shadow_wr(4'd3, 16'h0033);
        upd_evt = 1'b1; tick();
        check_write("ovr_ch0", BASE + 32'h30, 32'h11);
        tick(); upd_evt = 1'b0;
        check_val("ovr_pulse", 32'(overrun), 32'd1);
        check_write("ovr_ch1", BASE + 32'h34, 32'h22);
        shadow_we = 1'b1; shadow_sel = 4'd0; shadow_data = 16'h0099;
        tick(); shadow_we = 1'b0;
        check_val("ovr_pulse_end", 32'(overrun), 32'd0);
        check_write("ovr_ch3", BASE + 32'h3C, 32'h33);
        check_val("ovr_repend", 32'(pending), 32'h001);
        tick();
        check_val("ovr_done", 32'(done), 32'd1);
        check_val("ovr_no_extra", 32'(m_wen), 32'd0);
        tick();
        upd_evt = 1'b1; tick(); upd_evt = 1'b0;
        check_write("ovr_rewrite", BASE + 32'h30, 32'h99);
        tick();
        check_val("ovr_rewrite_done", 32'(done), 32'd1);
        tick();

        // Slave error on ch0 does not stop the sequence.
        shadow_wr(4'd0, 16'h000A);
        shadow_wr(4'd4, 16'h000B);
        upd_evt = 1'b1; tick(); upd_evt = 1'b0;
        m_error = 1'b1;
        check_write("err_ch0", BASE + 32'h30, 32'hA);
        check_val("err_before", 32'(err_sticky), 32'd0);
        tick();
        m_error = 1'b0;
        check_val("err_set", 32'(err_sticky), 32'd1);
        check_write("err_ch4", BASE + 32'h40, 32'hB);
        tick();
        check_val("err_done", 32'(done), 32'd1);
        tick();
        check_val("err_hold", 32'(err_sticky), 32'd1);

`ifdef TIMER_SEQ_ARR_EN
        shadow_wr(4'd8, 16'h00FF);
        shadow_wr(4'd1, 16'h0007);
        check_val("arr_pending", 32'(pending), 32'h102);
        upd_evt = 1'b1; tick(); upd_evt = 1'b0;
        check_write("arr_first", BASE + 32'h0C, 32'hFF);
        tick();
        check_write("arr_ch1", BASE + 32'h34, 32'h7);
        tick();
        check_val("arr_done", 32'(done), 32'd1);
        tick();
`else
        shadow_wr(4'd8, 16'h00FF);
        check_val("arr_ignored", 32'(pending), 32'd0);
        upd_evt = 1'b1; tick(); upd_evt = 1'b0;
        check_val("arr_no_busy", 32'(busy), 32'd0);
        check_val("arr_no_wen", 32'(m_wen), 32'd0);
        tick();
`endif

        // Reset mid-sequence.
        shadow_wr(4'd0, 16'h0001);
        shadow_wr(4'd1, 16'h0002);
        shadow_wr(4'd2, 16'h0003);
        shadow_wr(4'd3, 16'h0004);
        upd_evt = 1'b1; tick(); upd_evt = 1'b0;
        check_write("mid_ch0", BASE + 32'h30, 32'h1);
        shadow_we = 1'b1; shadow_sel = 4'd6; shadow_data = 16'h0066;
        tick(); shadow_we = 1'b0;
        check_write("mid_ch1", BASE + 32'h34, 32'h2);
        check_val("mid_pending", 32'(pending), 32'h040);
        rst = 1'b1; tick(); rst = 1'b0;
        check_val("mid_wen", 32'(m_wen), 32'd0);
        check_val("mid_pend_clr", 32'(pending), 32'd0);
        check_val("mid_busy", 32'(busy), 32'd0);
        check_val("mid_err_clr", 32'(err_sticky), 32'd0);
        tick();
        check_val("mid_wen2", 32'(m_wen), 32'd0);
        upd_evt = 1'b1; tick(); upd_evt = 1'b0;
        check_val("mid_active_clr", 32'(busy), 32'd0);
        check_val("mid_no_write", 32'(m_wen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
